// File: rtl/uart_tx_framer.sv
// uart_tx_framer: parameterised UART transmit framer with optional parity and 1/2 stop bits
module uart_tx_framer #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_tx_busy,
  output logic                         o_tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic has_par = (P_UART_CHECK == 1) || (P_UART_CHECK == 2);
  localparam logic odd = P_UART_CHECK == 2;
  localparam logic [3:0] last_data = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [3:0] last_stop = 4'(P_UART_STOP_WIDTH - 1);
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [P_UART_DATA_WIDTH-1:0] sr, sr_nxt;
  logic par, par_nxt, tx_nxt, ready_nxt, busy_nxt, done_nxt, accept;
  // Next-state logic; every output is the registered image of the state being entered
  always_comb begin
    accept = i_user_tx_valid && o_user_tx_ready;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? START : IDLE;
      START:   state_nxt = DATA;
      DATA:    state_nxt = (cnt == last_data) ? (has_par ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = (cnt == last_stop) ? (accept ? START : IDLE) : STOP;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt == state && state_nxt != IDLE) ? cnt + 4'd1 : 4'd0;
    sr_nxt = accept ? i_user_tx_data : (state == DATA) ? sr >> 1 : sr;
    par_nxt = accept ? 1'b0 : (state == DATA) ? par ^ sr[0] : par;
    tx_nxt = (state_nxt == START) ? 1'b0 :
             (state_nxt == DATA) ? sr_nxt[0] :
             (state_nxt == PARITY) ? par_nxt ^ odd : 1'b1;
    ready_nxt = state_nxt == IDLE || (state_nxt == STOP && cnt_nxt == last_stop);
    busy_nxt = state_nxt != IDLE;
    done_nxt = state == STOP && cnt == last_stop;
  end
  // State and output registers; reset aborts any frame and forces the line idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      par <= 1'b0;
      o_uart_tx <= 1'b1;
      o_user_tx_ready <= 1'b0;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      sr <= sr_nxt;
      par <= par_nxt;
      o_uart_tx <= tx_nxt;
      o_user_tx_ready <= ready_nxt;
      o_tx_busy <= busy_nxt;
      o_tx_done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed checks of four framer configurations sharing one clock and reset
module tb_uart_tx_framer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] d [4];
  logic vld [4];
  logic rdy [4];
  logic tx [4];
  logic busy [4];
  logic done [4];
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  uart_tx_framer u0 (.i_clk(clk), .i_rst(rst), .i_user_tx_data(d[0]), .i_user_tx_valid(vld[0]),
    .o_user_tx_ready(rdy[0]), .o_uart_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
  uart_tx_framer #(.P_UART_CHECK(2)) u1 (.i_clk(clk), .i_rst(rst), .i_user_tx_data(d[1]),
    .i_user_tx_valid(vld[1]), .o_user_tx_ready(rdy[1]), .o_uart_tx(tx[1]), .o_tx_busy(busy[1]),
    .o_tx_done(done[1]));
  uart_tx_framer #(.P_UART_CHECK(0)) u2 (.i_clk(clk), .i_rst(rst), .i_user_tx_data(d[2]),
    .i_user_tx_valid(vld[2]), .o_user_tx_ready(rdy[2]), .o_uart_tx(tx[2]), .o_tx_busy(busy[2]),
    .o_tx_done(done[2]));
  uart_tx_framer #(.P_UART_STOP_WIDTH(2)) u3 (.i_clk(clk), .i_rst(rst), .i_user_tx_data(d[3]),
    .i_user_tx_valid(vld[3]), .o_user_tx_ready(rdy[3]), .o_uart_tx(tx[3]), .o_tx_busy(busy[3]),
    .o_tx_done(done[3]));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input int k, input string tag);
    chk($sformatf("%s_tx%0d", tag, k), 16'(tx[k]), 16'h1);
    chk($sformatf("%s_rdy%0d", tag, k), 16'(rdy[k]), 16'h1);
    chk($sformatf("%s_busy%0d", tag, k), 16'(busy[k]), 16'h0);
  endtask
  task automatic launch(input int k, input logic [7:0] v);
    d[k] = v;
    vld[k] = 1'b1;
    step();
  endtask
  task automatic run(input int k, input logic [15:0] exp, input int len, input bit hold,
                     input logic [7:0] nv);
    if (hold) d[k] = nv;
    else vld[k] = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (!hold) d[k] = 8'($urandom);
      chk($sformatf("tx%0d_b%0d", k, i), 16'(tx[k]), 16'(exp[i]));
      chk($sformatf("busy%0d_b%0d", k, i), 16'(busy[k]), 16'h1);
      chk($sformatf("rdy%0d_b%0d", k, i), 16'(rdy[k]), 16'(i == len - 1));
      if (i > 0) chk($sformatf("done%0d_b%0d", k, i), 16'(done[k]), 16'h0);
      step();
    end
    chk($sformatf("done%0d_end", k), 16'(done[k]), 16'h1);
    chk($sformatf("tx%0d_end", k), 16'(tx[k]), hold ? 16'h0 : 16'h1);
    chk($sformatf("busy%0d_end", k), 16'(busy[k]), hold ? 16'h1 : 16'h0);
    chk($sformatf("rdy%0d_end", k), 16'(rdy[k]), hold ? 16'h0 : 16'h1);
    if (!hold) begin
      step();
      chk($sformatf("done%0d_pulse", k), 16'(done[k]), 16'h0);
    end
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      d[k] = 8'h00;
      vld[k] = 1'b0;
    end
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_tx%0d", k), 16'(tx[k]), 16'h1);
      chk($sformatf("rst_rdy%0d", k), 16'(rdy[k]), 16'h0);
      chk($sformatf("rst_busy%0d", k), 16'(busy[k]), 16'h0);
      chk($sformatf("rst_done%0d", k), 16'(done[k]), 16'h0);
    end
    step();
    chk("rst_hold_rdy", 16'(rdy[0]), 16'h0);
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) idle_chk(k, "post_rst");
    launch(0, 8'hA5);
    run(0, 16'h54A, 11, 1'b0, 8'h00);
    launch(1, 8'hA5);
    run(1, 16'h74A, 11, 1'b0, 8'h00);
    launch(2, 8'h3C);
    run(2, 16'h278, 10, 1'b0, 8'h00);
    launch(3, 8'h00);
    run(3, 16'hC00, 12, 1'b0, 8'h00);
    launch(0, 8'h01);
    run(0, 16'h602, 11, 1'b1, 8'hFF);
    run(0, 16'h5FE, 11, 1'b0, 8'h00);
    idle_chk(0, "b2b_idle");
    launch(0, 8'h00);
    vld[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_pre_tx", 16'(tx[0]), 16'h0);
    chk("abort_pre_busy", 16'(busy[0]), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", 16'(tx[0]), 16'h1);
    chk("abort_busy", 16'(busy[0]), 16'h0);
    chk("abort_rdy", 16'(rdy[0]), 16'h0);
    chk("abort_done", 16'(done[0]), 16'h0);
    step();
    chk("abort_hold_done", 16'(done[0]), 16'h0);
    rst = 1'b0;
    step();
    idle_chk(0, "abort_rel");
    chk("abort_rel_done", 16'(done[0]), 16'h0);
    step();
    idle_chk(0, "abort_idle");
    chk("abort_idle_done", 16'(done[0]), 16'h0);
    launch(0, 8'h5A);
    run(0, 16'h4B4, 11, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
